// File: rtl/sha3_wb_bridge.sv
// sha3_wb_bridge: Wishbone slave front-end for the SHA-3 core.
// Message FIFO -> valid/ready stream, digest capture registers and a
// maskable completion interrupt.
// Ports: wb_clk_i/wb_rst_i (sync, active-low), wbs_* Wishbone slave,
// msg_* stream to core, start_o pulse, digest_valid_i/digest_i, irq_o.
// Optional: define SHA3_LA_CTRL_EN to add la_data_in/la_oenb/la_data_out
// (logic-analyzer start/soft-clear control and status mirror).
module sha3_wb_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          DIGEST_WORDS = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic                      msg_valid_o,
  input  logic                      msg_ready_i,
  output logic [31:0]               msg_data_o,
  output logic                      msg_last_o,
  output logic                      start_o,
  input  logic                      digest_valid_i,
  input  logic [32*DIGEST_WORDS-1:0] digest_i,
  output logic                      irq_o
`ifdef SHA3_LA_CTRL_EN
  ,
  input  logic [127:0]              la_data_in,
  input  logic [127:0]              la_oenb,
  output logic [127:0]              la_data_out
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FEED = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic        ack_q;
  logic [31:0] dat_q;
  logic        done_q;
  logic        ovf_q;
  logic        irq_en_q;
  logic [32*DIGEST_WORDS-1:0] dig_q;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        hit;
  logic        req;
  logic        wr;
  logic [5:0]  off;
  logic        full;
  logic        empty;
  logic        start_req;
  logic        clr;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        la_start;
  logic        la_clr;
  logic [31:0] status;
  logic [31:0] rdata;
  logic [32:0] head;

  assign hit   = wbs_cyc_i & wbs_stb_i
               & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A new access is taken only while ack is low, so
  // back-to-back strobes are served every other cycle.
  assign req   = hit & ~ack_q;
  assign wr    = req & wbs_we_i;
  assign off   = wbs_adr_i[7:2];

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign start_req = (wr & (off == 6'd0) & wbs_dat_i[0]) | la_start;
  assign clr       = (wr & (off == 6'd0) & wbs_dat_i[1]) | la_clr;

  assign push_req = wr & ((off == 6'd2) | (off == 6'd3))
                  & (wbs_sel_i == 4'hF);
  // Full is the registered flag: a same-cycle pop does not make room.
  assign push     = push_req & ~full & ~clr;

  assign head        = mem[rd_ptr];
  assign msg_valid_o = ~empty & (state == S_FEED);
  assign msg_data_o  = head[31:0];
  assign msg_last_o  = head[32];
  assign pop         = msg_valid_o & msg_ready_i;

  assign status = {16'b0, 8'(count), 3'b0,
                   ovf_q, empty, full, done_q, (state != S_IDLE)};

  always_comb begin
    rdata = '0;
    case (off)
      6'd1: rdata = status;
      6'd4: rdata = {31'b0, irq_en_q};
      6'd5: rdata = {31'b0, done_q};
      default: begin
        if ((off[5:4] == 2'b01)
            && (int'(off[3:0]) < DIGEST_WORDS))
          rdata = dig_q[32*int'(off[3:0]) +: 32];
      end
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wr_ptr] <= {(off == 6'd3), wbs_dat_i};
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      start_o  <= 1'b0;
      irq_o    <= 1'b0;
      irq_en_q <= 1'b0;
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dig_q    <= '0;
    end else begin
      ack_q   <= req;
      dat_q   <= (req & ~wbs_we_i) ? rdata : '0;
      start_o <= 1'b0;
      irq_o   <= done_q & irq_en_q;
      if (wr & (off == 6'd4) & wbs_sel_i[0])
        irq_en_q <= wbs_dat_i[0];
      if (clr) begin
        state  <= S_IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
        dig_q  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: ;
        endcase
        if (wr & (off == 6'd5) & wbs_dat_i[0]) begin
          done_q <= 1'b0;
          ovf_q  <= 1'b0;
        end
        if (push_req & full)
          ovf_q <= 1'b1;
        case (state)
          S_IDLE: begin
            if (start_req) begin
              state   <= S_FEED;
              start_o <= 1'b1;
            end
          end
          S_FEED: begin
            if (pop & head[32])
              state <= S_WAIT;
          end
          S_WAIT: begin
            if (digest_valid_i) begin
              dig_q  <= digest_i;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SHA3_LA_CTRL_EN
  logic la_prev;
  logic unused_la;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i)
      la_prev <= 1'b0;
    else
      la_prev <= la_data_in[0];
  end

  assign la_start    = ~la_oenb[0] & la_data_in[0] & ~la_prev;
  assign la_clr      = ~la_oenb[1] & la_data_in[1];
  assign la_data_out = {64'b0, dig_q[31:0], 16'b0, status[15:0]};
  assign unused_la   = ^{la_data_in[127:2], la_oenb[127:2],
                         wbs_adr_i[1:0]};
`else
  logic unused_adr;

  assign la_start   = 1'b0;
  assign la_clr     = 1'b0;
  assign unused_adr = ^wbs_adr_i[1:0];
`endif

endmodule

// File: tb/tb_sha3_wb_bridge.sv
// tb_sha3_wb_bridge: directed self-checking bench for sha3_wb_bridge.
// Register table vectors plus hand-written FIFO/FSM/IRQ sequences.
module tb_sha3_wb_bridge;

  localparam logic [31:0] B = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = B + 32'h00;
  localparam logic [31:0] A_STAT = B + 32'h04;
  localparam logic [31:0] A_DATA = B + 32'h08;
  localparam logic [31:0] A_LAST = B + 32'h0C;
  localparam logic [31:0] A_IEN  = B + 32'h10;
  localparam logic [31:0] A_IST  = B + 32'h14;
  localparam logic [31:0] A_DIG  = B + 32'h40;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         stb = 0, cyc = 0, we = 0;
  logic [3:0]   sel = 0;
  logic [31:0]  adr = 0, wdat = 0;
  logic         ack;
  logic [31:0]  rdat;
  logic         msg_valid, msg_ready = 0, msg_last;
  logic [31:0]  msg_data;
  logic         start;
  logic         dvalid = 0;
  logic [255:0] digest = '0;
  logic         irq;

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  logic [32:0] q[$];

  sha3_wb_bridge dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i(we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .msg_valid_o(msg_valid),
    .msg_ready_i(msg_ready),
    .msg_data_o(msg_data),
    .msg_last_o(msg_last),
    .start_o(start),
    .digest_valid_i(dvalid),
    .digest_i(digest),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start) n_start++;
      if (msg_valid && msg_ready) q.push_back({msg_last, msg_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic acked);
    @(posedge clk); #2;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    acked = 0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      if (!acked) begin
        @(posedge clk); #1;
        if (ack) begin
          acked = 1;
          rd = rdat;
          cyc = 0; stb = 0; we = 0;
        end
      end
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic acked;
    xfer(a, 1'b1, d, 4'hF, rd, acked);
    if (!acked) begin
      n_chk++; n_err++;
      $display("FAIL wr_ack %h: got 0 expected 1", a);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic acked;
    xfer(a, 1'b0, 32'h0, 4'hF, rd, acked);
    check(nm, {31'b0, acked, rd}, {32'd1, exp});
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic acked;
    logic seen;

    tbl[0]  = '{A_STAT, 0, 0, 4'hF, 1, 32'h0000_0008};
    tbl[1]  = '{A_DIG,  0, 0, 4'hF, 1, 32'h0};
    tbl[2]  = '{A_CTRL, 0, 0, 4'hF, 1, 32'h0};
    tbl[3]  = '{A_IEN,  1, 1, 4'h1, 0, 32'h0};
    tbl[4]  = '{A_IEN,  0, 0, 4'hF, 1, 32'h1};
    tbl[5]  = '{A_IEN,  1, 0, 4'h2, 0, 32'h0};
    tbl[6]  = '{A_IEN,  0, 0, 4'hF, 1, 32'h1};
    tbl[7]  = '{A_IEN,  1, 0, 4'hF, 0, 32'h0};
    tbl[8]  = '{A_IEN,  0, 0, 4'hF, 1, 32'h0};
    tbl[9]  = '{B + 32'h20, 0, 0, 4'hF, 1, 32'h0};
    tbl[10] = '{B + 32'h60, 0, 0, 4'hF, 1, 32'h0};

    cyc_wait(3);
    @(negedge clk);
    check("rst_irq", {63'b0, irq}, 64'd0);
    check("rst_valid", {63'b0, msg_valid}, 64'd0);
    #2 rst_n = 1;

    foreach (tbl[i]) begin
      xfer(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, rd, acked);
      if (tbl[i].chk)
        check($sformatf("tbl%0d", i), {31'b0, acked, rd},
              {32'd1, tbl[i].exp});
    end

    // basic message
    wr(A_DATA, 32'hA5A5_0001);
    wr(A_LAST, 32'hA5A5_0002);
    rd_chk("lvl2", A_STAT, 32'h0000_0200);
    msg_ready = 1;
    wr(A_CTRL, 32'h1);
    cyc_wait(6);
    check("n_start", 64'(n_start), 64'd1);
    check("n_pop", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      check("word0", 64'(q[0]), {31'b0, 1'b0, 32'hA5A5_0001});
      check("word1", 64'(q[1]), {31'b0, 1'b1, 32'hA5A5_0002});
    end
    rd_chk("wait_busy", A_STAT, 32'h0000_0009);

    // digest capture and irq
    wr(A_IEN, 32'h1);
    for (int k = 0; k < 8; k++)
      digest[32*k +: 32] = 32'h1000_0000 + 32'(k);
    @(posedge clk); #2 dvalid = 1;
    @(posedge clk); #2 dvalid = 0;
    cyc_wait(3);
    @(negedge clk);
    check("irq_rise", {63'b0, irq}, 64'd1);
    rd_chk("dig3", A_DIG + 32'h0C, 32'h1000_0003);
    rd_chk("dig7", A_DIG + 32'h1C, 32'h1000_0007);
    rd_chk("stat_done", A_STAT, 32'h0000_000A);
    rd_chk("ist1", A_IST, 32'h1);
    wr(A_IST, 32'h1);
    cyc_wait(2);
    @(negedge clk);
    check("irq_fall", {63'b0, irq}, 64'd0);
    rd_chk("ist0", A_IST, 32'h0);
    digest = '1;
    @(posedge clk); #2 dvalid = 1;
    @(posedge clk); #2 dvalid = 0;
    rd_chk("dig0_hold", A_DIG, 32'h1000_0000);

    // overflow
    msg_ready = 0;
    q.delete();
    for (int i = 0; i < 9; i++)
      wr(A_DATA, 32'hB000_0000 + 32'(i));
    rd_chk("full_ovf", A_STAT, 32'h0000_0814);
    wr(A_CTRL, 32'h1);
    msg_ready = 1;
    cyc_wait(12);
    check("ovf_npop", 64'(q.size()), 64'd8);
    if (q.size() == 8)
      check("ovf_word7", 64'(q[7]), {31'b0, 1'b0, 32'hB000_0007});
    rd_chk("feed_stall", A_STAT, 32'h0000_0019);
    wr(A_CTRL, 32'h2);
    rd_chk("clr1", A_STAT, 32'h0000_0008);

    // soft clear mid-message
    msg_ready = 0;
    q.delete();
    for (int i = 0; i < 3; i++)
      wr(A_DATA, 32'hC000_0000 + 32'(i));
    wr(A_CTRL, 32'h1);
    cyc_wait(2);
    @(negedge clk);
    check("stall_valid", {63'b0, msg_valid}, 64'd1);
    wr(A_CTRL, 32'h2);
    seen = 0;
    msg_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (msg_valid) seen = 1;
    end
    check("clr_novalid", {63'b0, seen}, 64'd0);
    check("clr_npop", 64'(q.size()), 64'd0);
    rd_chk("clr2", A_STAT, 32'h0000_0008);

    // partial sel and out-of-window
    xfer(A_DATA, 1'b1, 32'hDEAD_BEEF, 4'h3, rd, acked);
    check("sel3_ack", {63'b0, acked}, 64'd1);
    rd_chk("sel3_lvl", A_STAT, 32'h0000_0008);
    xfer(B + 32'h108, 1'b1, 32'h1234_5678, 4'hF, rd, acked);
    check("oow_ack", {63'b0, acked}, 64'd0);
    rd_chk("oow_lvl", A_STAT, 32'h0000_0008);

    // clear beats start in one write
    wr(A_CTRL, 32'h3);
    cyc_wait(2);
    check("clr_start", 64'(n_start), 64'd3);
    rd_chk("clr3", A_STAT, 32'h0000_0008);

    // reset mid-message
    msg_ready = 0;
    wr(A_IEN, 32'h1);
    wr(A_DATA, 32'hE000_0000);
    wr(A_DATA, 32'hE000_0001);
    wr(A_CTRL, 32'h1);
    @(posedge clk); #2 rst_n = 0;
    cyc_wait(2);
    #2 rst_n = 1;
    rd_chk("rst_stat", A_STAT, 32'h0000_0008);
    rd_chk("rst_ien", A_IEN, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sha3_wb_bridge.md
Name: sha3_wb_bridge

Overview:
Wishbone slave front-end for the SHA-3 core, generalising the single-register controller path. It buffers message words in a parametrised FIFO and streams them to the core over a valid/ready interface. It captures a parametrised-width digest into readable registers and raises a maskable completion interrupt. It sits between the Caravel Wishbone bus (user area 1) and the hash datapath.

Parameters:
BASE_ADDR, 32'h3000_0000, block base; decode window is adr[31:8]==BASE_ADDR[31:8]
FIFO_DEPTH, 8, message FIFO depth in 32-bit words; power of 2, 2..64
DIGEST_WORDS, 8, digest width in 32-bit words, 1..16

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous reset, active-low
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
msg_valid_o  out  1  message word valid to core
msg_ready_i  in  1  core accepts word
msg_data_o  out  32  message word (FIFO head)
msg_last_o  out  1  head word is final word of message
start_o  out  1  one-cycle pulse: new hash begins
digest_valid_i  in  1  core digest valid (one-cycle pulse)
digest_i  in  32*DIGEST_WORDS  core digest; word k = bits [32k+31:32k]
irq_o  out  1  completion interrupt, level

Behaviour:
- Reset (wb_rst_i==0 at a clock edge): ack=0, dat_o=0, msg_valid_o=0, start_o=0, irq_o=0, FIFO empty, FSM IDLE, all flags, IRQ_EN and digest registers = 0.
- Bus: access = cyc&stb&address in window. ack asserts the cycle after an access with ack low and stays high 1 cycle; back-to-back accesses ack every other cycle. Out-of-window accesses are never acked. dat_o is registered with ack and is 0 when no ack.
- Register map (offset from BASE_ADDR):
  0x00 CTRL: W bit0 start, bit1 soft clear (self-clearing strobes); reads 0.
  0x04 STATUS: R bit0 busy (FSM!=IDLE), bit1 done, bit2 full, bit3 empty, bit4 overflow, [15:8] FIFO level.
  0x08 MSG_DATA: W push word, last=0.
  0x0C MSG_LAST: W push word, last=1.
  0x10 IRQ_EN: R/W bit0, honours wbs_sel_i[0].
  0x14 IRQ_STAT: R bit0=done; writing 1 to bit0 clears done and overflow.
  0x40+4k DIGEST[k], k<DIGEST_WORDS: R only.
  Other in-window offsets: acked, read 0, writes ignored.
- Pushes require wbs_sel_i==4'hF; otherwise acked and ignored. A push is accepted only if the registered full flag is 0. This holds even if a pop occurs in the same cycle. A rejected push sets sticky overflow.
- FIFO: first-word-fall-through. msg_valid_o = !empty and FSM==FEED. A pop occurs on msg_valid_o&msg_ready_i. Simultaneous push and pop keeps the level unchanged.
- FSM:
  IDLE: on start write go to FEED and pulse start_o for 1 cycle.
  FEED: pop words. When a popped word has last=1, go to WAIT. An empty FIFO stalls in FEED.
  WAIT: on digest_valid_i, latch all digest_i into DIGEST regs, set done, go to DONE.
  DONE: go to IDLE next cycle.
  Start writes outside IDLE are ignored. digest_valid_i outside WAIT is ignored.
- irq_o = done & IRQ_EN[0], registered (1-cycle lag).
- Soft clear, from any state: next cycle FIFO empty, FSM IDLE, done/overflow=0, DIGEST=0; IRQ_EN is kept. Soft clear wins over a simultaneous start in the same write.
- Reset mid-message behaves like soft clear plus IRQ_EN=0. A pending ack is dropped.

Optional Feature:
SHA3_LA_CTRL_EN. When defined, adds ports la_data_in[127:0] (in), la_oenb[127:0] (in), la_data_out[127:0] (out).
- When la_oenb[0]==0, a 0->1 transition of la_data_in[0] (registered edge detect) acts as a CTRL start.
- When la_oenb[1]==0, la_data_in[1]==1 acts as a soft clear.
- la_data_out = {64'b0, DIGEST[0], 16'b0, STATUS[15:0]}.
When not defined: the ports are absent, and only Wishbone controls the block.

Test Plan:
- Reset, then read STATUS -> 0x0000_0008 (empty); read DIGEST[0] -> 0; irq_o=0.
- Push 0xA5A5_0001, 0xA5A5_0002 (MSG_LAST), write CTRL=1, msg_ready_i=1 -> start_o pulses once; words appear in order, second with msg_last_o=1; then WAIT with STATUS busy=1.
- In WAIT, drive digest_valid_i with word k = 0x1000_0000+k -> DIGEST[3] reads 0x1000_0003. With IRQ_EN=1, irq_o rises; writing IRQ_STAT=1 drops irq_o and done.
- Push FIFO_DEPTH+1 words with msg_ready_i=0 -> level=8, full=1, overflow=1; the 9th word is never emitted.
- Push 3 words (no last), start, stall msg_ready_i, then soft clear -> STATUS=0x0000_0008, FSM IDLE, no further msg_valid_o.
- Write MSG_DATA with sel=4'h3 -> acked, level unchanged; an out-of-window address gets no ack within 4 cycles.
